// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// Holds the funct3 width/sign codes, fault cause codes, the FSM state
// encoding and small decode helpers used by the FSM and the lane aligner.
package load_store_unit_pkg;

  // funct3 codes; bits [1:0] give the access size, bit 2 marks unsigned loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] CAUSE_NONE           = 2'b00;
  localparam logic [1:0] CAUSE_LOAD_MISALIGN  = 2'b01;
  localparam logic [1:0] CAUSE_STORE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL        = 2'b11;

  localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
  localparam logic [2:0] ST_ISSUE_ENC    = 3'd1;
  localparam logic [2:0] ST_WAIT_RSP_ENC = 3'd2;
  localparam logic [2:0] ST_WB_ENC       = 3'd3;
  localparam logic [2:0] ST_FAULT_ENC    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_ISSUE    = ST_ISSUE_ENC,
    ST_WAIT_RSP = ST_WAIT_RSP_ENC,
    ST_WB       = ST_WB_ENC,
    ST_FAULT    = ST_FAULT_ENC
  } state_t;

  // Exactly one of load/store must be set, with a funct3 listed for that kind.
  function automatic logic is_legal_op(input logic is_load, input logic is_store,
                                       input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    if (is_load && !is_store) begin
      legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end else if (is_store && !is_load) begin
      legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end
    return legal;
  endfunction

  // Only meaningful for a legal funct3.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (funct3[1:0] == SIZE_HALF) mis = offset[0];
    else if (funct3[1:0] == SIZE_WORD) mis = (offset != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane aligner.
// Ports:
//   funct3      width/sign code of the access
//   offset      effective address bits [1:0]
//   store_data  rs2 data for stores
//   rdata       word returned by memory
//   lane_wdata  store data replicated onto the byte lanes
//   lane_wstrb  byte enables for the store
//   load_data   load value shifted down and sign/zero-extended
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wstrb,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    lane_wdata = store_data;
    lane_wstrb = 4'b1111;
    case (funct3[1:0])
      SIZE_BYTE: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_wstrb = 4'b0001 << offset;
      end
      SIZE_HALF: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_wstrb = 4'b0011 << offset;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    load_data = shifted;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data = {24'b0, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: takes the effective address from execute, issues one
// word-aligned request on the data-memory port, formats load data for
// writeback and raises a fault pulse for illegal or misaligned operations.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_*                            operation from execute (valid/ready)
//   mem_req_*, mem_we/addr/wdata/wstrb  data-memory request (valid/ready)
//   mem_rsp_valid, mem_rdata         read response
//   wb_valid, wb_rd, wb_data         load writeback packet
//   store_done                       store accepted by memory
//   fault_valid/cause/addr           fault report
//
// state    | meaning
// IDLE     | ready to accept an operation
// ISSUE    | memory request held until mem_req_ready
// WAIT_RSP | load issued, waiting for read data
// WB       | one-cycle writeback pulse
// FAULT    | one-cycle fault pulse, no memory access
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_load,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [RD_WIDTH-1:0]   req_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rdata,
  output logic                  wb_valid,
  output logic [RD_WIDTH-1:0]   wb_rd,
  output logic [31:0]           wb_data,
  output logic                  store_done,
  output logic                  fault_valid,
  output logic [1:0]            fault_cause,
  output logic [ADDR_WIDTH-1:0] fault_addr
);

  state_t                state, state_nxt;
  logic                  op_is_load;
  logic [2:0]            op_funct3;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [31:0]           op_wdata;
  logic [RD_WIDTH-1:0]   op_rd;
  logic [1:0]            op_cause;
  logic [1:0]            cause_nxt;
  logic [RD_WIDTH-1:0]   wb_rd_q;
  logic [31:0]           wb_data_q;
  logic [31:0]           lane_wdata;
  logic [3:0]            lane_wstrb;
  logic [31:0]           load_data;
  logic                  accept;

  lsu_align u_align (
    .funct3     (op_funct3),
    .offset     (op_addr[1:0]),
    .store_data (op_wdata),
    .rdata      (mem_rdata),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .load_data  (load_data)
  );

  assign accept = req_valid && (state == ST_IDLE);

  // Illegal-op check wins over misalignment.
  always_comb begin
    cause_nxt = CAUSE_NONE;
    if (!is_legal_op(req_is_load, req_is_store, req_funct3)) begin
      cause_nxt = CAUSE_ILLEGAL;
    end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
      cause_nxt = req_is_load ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = 4'b0000;
    store_done    = 1'b0;
    wb_valid      = 1'b0;
    fault_valid   = 1'b0;
    fault_cause   = CAUSE_NONE;
    fault_addr    = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (cause_nxt == CAUSE_NONE) ? ST_ISSUE : ST_FAULT;
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_addr      = {op_addr[ADDR_WIDTH-1:2], 2'b00};
        if (!op_is_load) begin
          mem_we    = 1'b1;
          mem_wdata = lane_wdata;
          mem_wstrb = lane_wstrb;
        end
        if (mem_req_ready) begin
          store_done = !op_is_load;
          state_nxt  = op_is_load ? ST_WAIT_RSP : ST_IDLE;
        end
      end
      ST_WAIT_RSP: begin
        if (mem_rsp_valid) state_nxt = ST_WB;
      end
      ST_WB: begin
        wb_valid  = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_FAULT: begin
        fault_valid = 1'b1;
        fault_cause = op_cause;
        fault_addr  = op_addr;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_is_load <= 1'b0;
      op_funct3  <= 3'b000;
      op_addr    <= '0;
      op_wdata   <= '0;
      op_rd      <= '0;
      op_cause   <= CAUSE_NONE;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      if (accept) begin
        op_is_load <= req_is_load;
        op_funct3  <= req_funct3;
        op_addr    <= req_addr;
        op_wdata   <= req_wdata;
        op_rd      <= req_rd;
        op_cause   <= cause_nxt;
      end
      // Writeback fields persist until the next load completes.
      if ((state == ST_WAIT_RSP) && mem_rsp_valid) begin
        wb_rd_q   <= op_rd;
        wb_data_q <= load_data;
      end
    end
  end

  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_load = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_done;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .RD_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .store_done(store_done),
    .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  // kind: 0 = no completion within budget, 1 = writeback, 2 = store done, 3 = fault
  typedef struct {
    int          kind;
    int          done_cyc;
    int          hs_cyc;
    int          valid_cycles;
    bit          stable;
    bit          busy_ready;
    bit          accepted;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;
    logic        m_we;
    logic [31:0] r_data;
    logic [4:0]  r_rd;
    logic [1:0]  r_cause;
    logic [31:0] r_faddr;
  } res_t;

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] ref_cause(input logic ld, input logic st,
                                           input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    if (ld == st) return 2'b11;
    if (ld) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else    legal = (f3 <= 2);
    if (!legal) return 2'b11;
    if ((int'(addr[1:0]) % ref_size(f3)) != 0) return ld ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int     size;
    int     o;
    longint u;
    size = ref_size(f3);
    o    = int'(addr[1:0]);
    u    = longint'(rdata >> (8 * o)) % (longint'(1) << (8 * size));
    if (!f3[2] && size < 4 && u >= (longint'(1) << (8 * size - 1)))
      u = u - (longint'(1) << (8 * size));
    return 32'(u);
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int o;
    int size;
    s = 4'b0000;
    o = int'(addr[1:0]);
    size = ref_size(f3);
    for (int i = 0; i < 4; i++) if (i >= o && i < o + size) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int size;
    size = ref_size(f3);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % size) +: 8];
    return w;
  endfunction

  // ---------------- driver: one operation, memory with configurable stall ----------------
  // Entered and left just after a rising edge with the unit idle.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int stall, output res_t r);
    int hs;
    r.kind = 0; r.done_cyc = -1; r.hs_cyc = -1; r.valid_cycles = 0;
    r.stable = 1'b1; r.busy_ready = 1'b0; r.accepted = 1'b0;
    r.m_addr = '0; r.m_wdata = '0; r.m_strb = '0; r.m_we = 1'b0;
    r.r_data = '0; r.r_rd = '0; r.r_cause = '0; r.r_faddr = '0;
    hs = -1;
    req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    r.accepted = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 1; n <= 40 && r.kind == 0; n++) begin
      mem_req_ready = (n > stall);
      mem_rsp_valid = (hs > 0 && n == hs + 1);
      mem_rdata     = rdata;
      @(negedge clk);
      if (req_ready) r.busy_ready = 1'b1;
      if (mem_req_valid) begin
        if (r.valid_cycles == 0) begin
          r.m_addr = mem_addr; r.m_wdata = mem_wdata; r.m_strb = mem_wstrb; r.m_we = mem_we;
        end else if (r.m_addr !== mem_addr || r.m_wdata !== mem_wdata ||
                     r.m_strb !== mem_wstrb || r.m_we !== mem_we) begin
          r.stable = 1'b0;
        end
        r.valid_cycles++;
        if (mem_req_ready) begin hs = n; r.hs_cyc = n; end
      end
      if (wb_valid) begin r.kind = 1; r.r_data = wb_data; r.r_rd = wb_rd; end
      else if (store_done) r.kind = 2;
      else if (fault_valid) begin r.kind = 3; r.r_cause = fault_cause; r.r_faddr = fault_addr; end
      if (r.kind != 0) r.done_cyc = n;
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({mem_req_valid, mem_we, store_done, wb_valid, fault_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=00000", {mem_req_valid, mem_we, store_done, wb_valid, fault_valid});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, wb_rd, wb_data, fault_cause, fault_addr} !== '0) begin
      errors++;
      $display("FAIL reset_fields addr=%h wdata=%h strb=%b rd=%h wbdata=%h cause=%b faddr=%h",
               mem_addr, mem_wdata, mem_wstrb, wb_rd, wb_data, fault_cause, fault_addr);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_load_directed();
    res_t r;
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 0, r);
    checks++;
    if (r.accepted !== 1'b1 || r.kind != 1 || r.hs_cyc != 1 || r.done_cyc != 3) begin
      errors++;
      $display("FAIL lw_timing acc=%b kind=%0d hs=%0d wb=%0d exp acc=1 kind=1 hs=1 wb=3",
               r.accepted, r.kind, r.hs_cyc, r.done_cyc);
    end
    checks++;
    if (r.m_addr !== 32'h100 || r.m_we !== 1'b0 || r.m_strb !== 4'b0000) begin
      errors++;
      $display("FAIL lw_request addr=%h we=%b strb=%b exp addr=00000100 we=0 strb=0000", r.m_addr, r.m_we, r.m_strb);
    end
    checks++;
    if (r.r_data !== 32'hDEADBEEF || r.r_rd !== 5'd7) begin
      errors++; $display("FAIL lw_data got=%h rd=%0d exp=deadbeef rd=7", r.r_data, r.r_rd);
    end
    do_op(1, 0, 3'b000, 32'h203, 32'h0, 5'd3, 32'h80112233, 0, r);
    checks++;
    if (r.kind != 1 || r.r_data !== 32'hFFFFFF80 || r.m_addr !== 32'h200) begin
      errors++; $display("FAIL lb_data kind=%0d got=%h addr=%h exp=ffffff80 addr=00000200", r.kind, r.r_data, r.m_addr);
    end
    do_op(1, 0, 3'b100, 32'h203, 32'h0, 5'd4, 32'h80112233, 0, r);
    checks++;
    if (r.kind != 1 || r.r_data !== 32'h00000080) begin
      errors++; $display("FAIL lbu_data kind=%0d got=%h exp=00000080", r.kind, r.r_data);
    end
    do_op(1, 0, 3'b101, 32'h202, 32'h0, 5'd5, 32'h80112233, 0, r);
    checks++;
    if (r.kind != 1 || r.r_data !== 32'h00008011) begin
      errors++; $display("FAIL lhu_data kind=%0d got=%h exp=00008011", r.kind, r.r_data);
    end
    checks++;
    if (wb_data !== 32'h00008011 || wb_rd !== 5'd5) begin
      errors++; $display("FAIL wb_hold got=%h rd=%0d exp=00008011 rd=5", wb_data, wb_rd);
    end
  endtask

  task automatic test_store_stall();
    res_t r;
    do_op(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 5'd0, 32'h0, 3, r);
    checks++;
    if (r.valid_cycles != 4 || r.stable !== 1'b1) begin
      errors++; $display("FAIL sh_stall valid_cycles=%0d stable=%b exp 4 1", r.valid_cycles, r.stable);
    end
    checks++;
    if (r.m_wdata !== 32'hABCDABCD || r.m_strb !== 4'b1100 || r.m_we !== 1'b1 || r.m_addr !== 32'h300) begin
      errors++;
      $display("FAIL sh_lanes wdata=%h strb=%b we=%b addr=%h exp abcdabcd 1100 1 00000300",
               r.m_wdata, r.m_strb, r.m_we, r.m_addr);
    end
    checks++;
    if (r.kind != 2 || r.done_cyc != 4 || r.hs_cyc != 4 || r.busy_ready) begin
      errors++;
      $display("FAIL sh_done kind=%0d done=%0d hs=%0d busy_ready=%b exp 2 4 4 0", r.kind, r.done_cyc, r.hs_cyc, r.busy_ready);
    end
  endtask

  task automatic test_faults();
    res_t r;
    do_op(1, 0, 3'b010, 32'h101, 32'h0, 5'd1, 32'h0, 0, r);
    checks++;
    if (r.kind != 3 || r.done_cyc != 1 || r.r_cause !== 2'b01 || r.r_faddr !== 32'h101 || r.valid_cycles != 0) begin
      errors++;
      $display("FAIL lw_misalign kind=%0d cyc=%0d cause=%b addr=%h memreq=%0d exp 3 1 01 00000101 0",
               r.kind, r.done_cyc, r.r_cause, r.r_faddr, r.valid_cycles);
    end
    do_op(0, 1, 3'b001, 32'h7, 32'h1234, 5'd0, 32'h0, 0, r);
    checks++;
    if (r.kind != 3 || r.r_cause !== 2'b10 || r.r_faddr !== 32'h7 || r.valid_cycles != 0) begin
      errors++;
      $display("FAIL sh_misalign kind=%0d cause=%b addr=%h memreq=%0d exp 3 10 00000007 0",
               r.kind, r.r_cause, r.r_faddr, r.valid_cycles);
    end
    do_op(0, 1, 3'b011, 32'h7, 32'h1234, 5'd0, 32'h0, 0, r);
    checks++;
    if (r.kind != 3 || r.r_cause !== 2'b11 || r.valid_cycles != 0) begin
      errors++; $display("FAIL st_illegal kind=%0d cause=%b memreq=%0d exp 3 11 0", r.kind, r.r_cause, r.valid_cycles);
    end
    do_op(1, 1, 3'b010, 32'h40, 32'h0, 5'd2, 32'h0, 0, r);
    checks++;
    if (r.kind != 3 || r.r_cause !== 2'b11) begin
      errors++; $display("FAIL both_flags kind=%0d cause=%b exp 3 11", r.kind, r.r_cause);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_wb;
    saw_wb = 1'b0;
    req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h40; req_rd = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    // now waiting for the read response
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (wb_valid) saw_wb = 1'b1;
    end
    checks++;
    if (saw_wb) begin errors++; $display("FAIL late_rsp_wb got=1 exp=0"); end
    checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle ready=%b memreq=%b exp 1 0", req_ready, mem_req_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic        ld [3];
    logic [2:0]  f3 [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [31:0] rdv [3];
    int acc_cyc [3];
    int done_cyc [3];
    int kinds [3];
    logic [31:0] got [3];
    int acc_cnt, done_cnt;
    bit busy_err, rsp_pend;
    ld[0] = 1; f3[0] = 3'b010; ad[0] = 32'h10; wd[0] = 0;            rdv[0] = $urandom;
    ld[1] = 0; f3[1] = 3'b010; ad[1] = 32'h20; wd[1] = $urandom;     rdv[1] = 0;
    ld[2] = 1; f3[2] = 3'b001; ad[2] = 32'h32; wd[2] = 0;            rdv[2] = $urandom;
    acc_cnt = 0; done_cnt = 0; busy_err = 0; rsp_pend = 0;
    for (int i = 0; i < 3; i++) begin acc_cyc[i] = -1; done_cyc[i] = -1; kinds[i] = 0; got[i] = '0; end
    mem_req_ready = 1'b1;
    for (int n = 0; n < 60 && done_cnt < 3; n++) begin
      if (acc_cnt < 3) begin
        req_valid = 1'b1; req_is_load = ld[acc_cnt]; req_is_store = !ld[acc_cnt];
        req_funct3 = f3[acc_cnt]; req_addr = ad[acc_cnt]; req_wdata = wd[acc_cnt]; req_rd = 5'(acc_cnt + 10);
      end else req_valid = 1'b0;
      mem_rsp_valid = rsp_pend;
      mem_rdata = (done_cnt < 3) ? rdv[done_cnt] : 32'h0;
      rsp_pend = 1'b0;
      @(negedge clk);
      if (acc_cnt > done_cnt && req_ready) busy_err = 1'b1;
      if (mem_req_valid && mem_req_ready && !mem_we) rsp_pend = 1'b1;
      if ((wb_valid || store_done) && done_cnt < 3) begin
        kinds[done_cnt] = wb_valid ? 1 : 2;
        got[done_cnt] = wb_valid ? wb_data : mem_wdata;
        done_cyc[done_cnt] = n;
        done_cnt++;
      end
      if (req_valid && req_ready && acc_cnt < 3) begin acc_cyc[acc_cnt] = n; acc_cnt++; end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    checks++;
    if (acc_cnt != 3 || done_cnt != 3 || busy_err) begin
      errors++; $display("FAIL b2b_counts acc=%0d done=%0d busy_ready=%b exp 3 3 0", acc_cnt, done_cnt, busy_err);
    end
    checks++;
    if (kinds[0] != 1 || kinds[1] != 2 || kinds[2] != 1) begin
      errors++; $display("FAIL b2b_order kinds=%0d,%0d,%0d exp 1,2,1", kinds[0], kinds[1], kinds[2]);
    end
    checks++;
    if (acc_cyc[0] != 0 || done_cyc[0] != 3 || acc_cyc[1] != 4 || done_cyc[1] != 5 ||
        acc_cyc[2] != 6 || done_cyc[2] != 9) begin
      errors++;
      $display("FAIL b2b_timing acc=%0d,%0d,%0d done=%0d,%0d,%0d exp acc=0,4,6 done=3,5,9",
               acc_cyc[0], acc_cyc[1], acc_cyc[2], done_cyc[0], done_cyc[1], done_cyc[2]);
    end
    checks++;
    if (got[0] !== ref_load(f3[0], ad[0], rdv[0]) || got[1] !== ref_wdata(f3[1], wd[1]) ||
        got[2] !== ref_load(f3[2], ad[2], rdv[2])) begin
      errors++;
      $display("FAIL b2b_data got=%h,%h,%h exp=%h,%h,%h", got[0], got[1], got[2],
               ref_load(f3[0], ad[0], rdv[0]), ref_wdata(f3[1], wd[1]), ref_load(f3[2], ad[2], rdv[2]));
    end
  endtask

  task automatic test_random();
    res_t        r;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    logic [4:0]  rd;
    logic [1:0]  cause;
    int          sel, stall, exp_done;
    for (int it = 0; it < 80; it++) begin
      sel = int'($urandom_range(0, 9));
      ld = (sel == 0) || (sel >= 2 && sel <= 5);
      st = (sel == 0) || (sel >= 6);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld && !st) begin
        sel = int'($urandom_range(0, 4));
        f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
      end else f3 = 3'($urandom_range(0, 2));
      addr = $urandom; wd = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      stall = int'($urandom_range(0, 2));
      cause = ref_cause(ld, st, f3, addr);
      do_op(ld, st, f3, addr, wd, rd, rdata, stall, r);
      if (cause != 2'b00) begin
        checks++;
        if (r.kind != 3 || r.done_cyc != 1 || r.r_cause !== cause || r.r_faddr !== addr || r.valid_cycles != 0) begin
          errors++;
          $display("FAIL rnd_fault it=%0d kind=%0d cyc=%0d cause=%b addr=%h memreq=%0d exp 3 1 %b %h 0",
                   it, r.kind, r.done_cyc, r.r_cause, r.r_faddr, r.valid_cycles, cause, addr);
        end
      end else if (ld) begin
        exp_done = stall + 3;
        checks++;
        if (r.kind != 1 || r.done_cyc != exp_done || r.r_data !== ref_load(f3, addr, rdata) || r.r_rd !== rd ||
            r.m_addr !== {addr[31:2], 2'b00} || r.m_we !== 1'b0 || r.m_strb !== 4'b0000 || !r.stable) begin
          errors++;
          $display("FAIL rnd_load it=%0d f3=%b kind=%0d cyc=%0d data=%h rd=%0d maddr=%h exp 1 %0d %h %0d %h",
                   it, f3, r.kind, r.done_cyc, r.r_data, r.r_rd, r.m_addr, exp_done,
                   ref_load(f3, addr, rdata), rd, {addr[31:2], 2'b00});
        end
      end else begin
        exp_done = stall + 1;
        checks++;
        if (r.kind != 2 || r.done_cyc != exp_done || r.m_wdata !== ref_wdata(f3, wd) ||
            r.m_strb !== ref_strb(f3, addr) || r.m_we !== 1'b1 || r.m_addr !== {addr[31:2], 2'b00} || !r.stable) begin
          errors++;
          $display("FAIL rnd_store it=%0d f3=%b kind=%0d cyc=%0d wdata=%h strb=%b maddr=%h exp 2 %0d %h %b %h",
                   it, f3, r.kind, r.done_cyc, r.m_wdata, r.m_strb, r.m_addr, exp_done,
                   ref_wdata(f3, wd), ref_strb(f3, addr), {addr[31:2], 2'b00});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_directed();
    test_store_stall();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the execute ALU.
- Takes the ALU-computed effective address (base + offset) plus rs2 store data. Issues one word-aligned request on a valid/ready data-memory port.
- For loads: aligns and sign/zero-extends the returned word, then hands a writeback packet to the register-file stage.
- Checks natural alignment and raises a fault pulse instead of touching memory when it fails.

Parameters:
- ADDR_WIDTH, 32, width of effective address and mem_addr.
- RD_WIDTH, 5, width of destination register index.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents an operation.
- req_ready  out  1  unit idle and able to accept.
- req_is_load  in  1  operation is a load.
- req_is_store  in  1  operation is a store.
- req_funct3  in  3  instruction[14:12] width/sign code.
- req_addr  in  ADDR_WIDTH  ALU result (effective address).
- req_wdata  in  32  rs2 data for stores.
- req_rd  in  RD_WIDTH  destination register for loads.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 4'b0000 for reads.
- mem_rsp_valid  in  1  read data valid (one cycle).
- mem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle load writeback pulse.
- wb_rd  out  RD_WIDTH  destination register.
- wb_data  out  32  extended load value.
- store_done  out  1  one-cycle pulse when a store is accepted by memory.
- fault_valid  out  1  one-cycle fault pulse.
- fault_cause  out  2  01 load misaligned, 10 store misaligned, 11 illegal op.
- fault_addr  out  ADDR_WIDTH  offending effective address.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except req_ready=1 after release. Any in-flight request is abandoned; a late mem_rsp_valid is ignored.
- States: IDLE, ISSUE, WAIT_RSP, WB, FAULT.
- req_ready=1 only in IDLE. Transfer occurs when req_valid & req_ready. On transfer, latch is_load, funct3, addr, wdata and rd.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000 SB, 001 SH, 010 SW.
- Illegal op → FAULT cause 11. Illegal means: is_load = is_store (both or neither), or an unlisted funct3.
- Misaligned → FAULT cause 01 (load) or 10 (store). Misaligned means: halfword with addr[0]=1, or word with addr[1:0]≠00. Illegal-op check has priority over misalignment.
- Otherwise IDLE → ISSUE.
- FAULT: fault_valid=1 and fault_addr=latched addr for exactly one cycle, then IDLE. No memory request is made.
- ISSUE:
  - mem_req_valid=1 and request fields stay stable until mem_req_ready.
  - On handshake, a store pulses store_done in the same cycle and goes to IDLE.
  - On handshake, a load goes to WAIT_RSP.
- Store lanes, with o = addr[1:0]:
  - SB: wdata = {4{b[7:0]}}, wstrb = 4'b0001<<o.
  - SH: wdata = {2{h[15:0]}}, wstrb = 4'b0011<<o.
  - SW: wdata = full word, wstrb = 4'b1111.
- WAIT_RSP: on mem_rsp_valid, register the formatted data and go to WB. mem_rsp_valid in any other state is ignored.
- Load formatting: shifted = mem_rdata >> (8*o).
  - LB / LBU: sign- / zero-extend shifted[7:0].
  - LH / LHU: sign- / zero-extend shifted[15:0].
  - LW: shifted as-is.
- WB: wb_valid=1 for one cycle with wb_rd and wb_data, then IDLE. wb_data and wb_rd hold their value until the next WB.
- Minimum latencies with zero memory wait:
  - Load: accept at T, handshake T+1, response T+2, wb_valid T+3.
  - Store: store_done at T+1.
  - Fault: fault_valid at T+1.
- Back-to-back: the next request can be accepted in the cycle after wb_valid, store_done or fault_valid.
- No internal queue; throughput is one operation in flight.

Decomposition:
- Shared package:
  - funct3 width codes (LB..LHU, SB..SW).
  - fault_cause codes.
  - state encoding localparams.
- Sub-module lsu_align: combinational store-lane generation and load extraction/extension. Reused by any later cache path. The FSM stays in load_store_unit.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, mem_req_ready and mem_rsp_valid asserted immediately → mem_addr 0x100, wb_valid at T+3 with wb_data 0xDEADBEEF.
- LB addr 0x203, rdata 0x80112233 → wb_data 0xFFFFFF80. LBU from the same address → 0x00000080. LHU addr 0x202 → 0x00008011.
- SH addr 0x302, wdata 0x0000ABCD, mem_req_ready held low 3 cycles → mem_req_valid and fields stable for 4 cycles, mem_wdata 0xABCDABCD, mem_wstrb 1100, store_done on the handshake cycle.
- LW addr 0x101 → fault_valid, cause 01, fault_addr 0x101, no mem_req_valid. SH addr 0x7 → cause 10. Store with funct3 011 → cause 11.
- rst_n driven low while in WAIT_RSP, then mem_rsp_valid pulses after release → no wb_valid, and req_ready=1.
- Three consecutive legal requests (load, store, load) with req_valid held → each accepted exactly once, in order, with req_ready=0 while busy.
